ysyx_23060025_keyed_lookup_table: RTL and testbench

//  Programmable, registered key->data lookup table. Successor to the combinational key mux.

---
 rtl/ysyx_23060025_keyed_lookup_table.sv | 110 +++++++++++
 tb/tb_ysyx_23060025_keyed_lookup_table.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_keyed_lookup_table.sv
// ysyx_23060025_keyed_lookup_table: run-time programmable key->data table with a registered valid/ready lookup.
// Full-table installs evict round-robin; lookups see the table as it was before same-cycle maintenance.
module ysyx_23060025_keyed_lookup_table #(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 8,
   parameter int DATA_LEN    = 32,
   parameter int HAS_DEFAULT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                wr_en,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                inv_en,
   input  logic [KEY_LEN-1:0]  inv_key,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [KEY_LEN-1:0]  req_key,
   input  logic [DATA_LEN-1:0] default_out,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_LEN-1:0] resp_data,
   output logic                resp_hit,
   output logic                full
);
   localparam int IW = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;
   logic [NR_KEY-1:0]   valid_q, valid_d;
   logic [KEY_LEN-1:0]  key_q [NR_KEY];
   logic [DATA_LEN-1:0] data_q [NR_KEY];
   logic [IW-1:0]       rr_q, rr_d, rr_next, wr_idx, free_idx, inv_idx, tgt_idx;
   logic                req_hit, wr_hit, inv_hit, free_found, accept;
   logic                resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
   logic [DATA_LEN-1:0] req_data, miss_data, resp_data_q, resp_data_d;
   // Descending scan so the lowest-index free entry wins; keys are unique so matches never collide.
   always_comb begin
      req_hit    = 1'b0;
      req_data   = '0;
      wr_hit     = 1'b0;
      wr_idx     = '0;
      inv_hit    = 1'b0;
      inv_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (valid_q[i] && key_q[i] == req_key) begin
            req_hit  = 1'b1;
            req_data = data_q[i];
         end
         if (valid_q[i] && key_q[i] == wr_key) begin
            wr_hit = 1'b1;
            wr_idx = IW'(i);
         end
         if (valid_q[i] && key_q[i] == inv_key) begin
            inv_hit = 1'b1;
            inv_idx = IW'(i);
         end
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end
   assign rr_next = (rr_q == IW'(NR_KEY - 1)) ? '0 : rr_q + 1'b1;
   assign tgt_idx = wr_hit ? wr_idx : free_found ? free_idx : rr_q;
   always_comb begin
      valid_d = valid_q;
      rr_d    = rr_q;
      if (flush) begin
         valid_d = '0;
         rr_d    = '0;
      end else if (wr_en) begin
         valid_d[tgt_idx] = 1'b1;
         rr_d             = (wr_hit || free_found) ? rr_q : rr_next;
      end else if (inv_en && inv_hit) begin
         valid_d[inv_idx] = 1'b0;
      end
   end
   assign miss_data    = (HAS_DEFAULT != 0) ? default_out : '0;
   assign req_ready    = !resp_valid_q || resp_ready;
   assign accept       = req_valid && req_ready;
   assign resp_valid_d = accept || (resp_valid_q && !resp_ready);
   assign resp_hit_d   = accept ? req_hit : resp_hit_q;
   assign resp_data_d  = accept ? (req_hit ? req_data : miss_data) : resp_data_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         rr_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         rr_q         <= rr_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_data_q  <= resp_data_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_en) begin
         key_q[tgt_idx]  <= wr_key;
         data_q[tgt_idx] <= wr_data;
      end
   end
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_data  = resp_data_q;
   assign full       = &valid_q;
endmodule

// File: tb/tb_ysyx_23060025_keyed_lookup_table.sv
// tb_ysyx_23060025_keyed_lookup_table: directed vectors against hand-computed expectations,
// one instance with a default miss value and one returning zero on miss, sharing stimulus.
module tb_ysyx_23060025_keyed_lookup_table;
   logic        clk = 1'b0;
   logic        rst, flush, wr_en, inv_en, req_valid, resp_ready;
   logic [7:0]  wr_key, inv_key, req_key;
   logic [31:0] wr_data, default_out;
   logic        req_ready, resp_valid, resp_hit, full;
   logic [31:0] resp_data;
   logic        nd_req_ready, nd_resp_valid, nd_resp_hit, nd_full;
   logic [31:0] nd_resp_data;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ysyx_23060025_keyed_lookup_table #(.HAS_DEFAULT(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
      .inv_en(inv_en), .inv_key(inv_key), .req_valid(req_valid), .req_ready(req_ready),
      .req_key(req_key), .default_out(default_out), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_hit(resp_hit), .full(full)
   );

   ysyx_23060025_keyed_lookup_table #(.HAS_DEFAULT(0)) u_nodef (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
      .inv_en(inv_en), .inv_key(inv_key), .req_valid(req_valid), .req_ready(nd_req_ready),
      .req_key(req_key), .default_out(default_out), .resp_valid(nd_resp_valid),
      .resp_ready(resp_ready), .resp_data(nd_resp_data), .resp_hit(nd_resp_hit), .full(nd_full)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] k, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_key  = k;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [7:0] k, input logic hit, input logic [31:0] d);
      req_valid = 1'b1;
      req_key   = k;
      tick();
      req_valid = 1'b0;
      check({tag, ".valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hit"}, 32'(resp_hit), 32'(hit));
      check({tag, ".data"}, resp_data, d);
      check({tag, ".nd_hit"}, 32'(nd_resp_hit), 32'(hit));
      check({tag, ".nd_data"}, nd_resp_data, hit ? d : 32'h0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; inv_en = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      wr_key = '0; inv_key = '0; req_key = '0; wr_data = '0; default_out = 32'hDEAD;
      tick();
      tick();
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.full", 32'(full), 32'd0);
      check("rst.req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      tick();
      // 1: miss after reset
      lookup("t1.miss", 8'h11, 1'b0, 32'hDEAD);
      // 2: in-place update keeps a single entry for the key
      wr(8'h11, 32'hA);
      wr(8'h22, 32'hB);
      wr(8'h11, 32'hC);
      lookup("t2.k11", 8'h11, 1'b1, 32'hC);
      lookup("t2.k22", 8'h22, 1'b1, 32'hB);
      check("t2.full0", 32'(full), 32'd0);
      wr(8'h44, 32'h1);
      check("t2.full3", 32'(full), 32'd0);
      wr(8'h55, 32'h2);
      check("t2.full4", 32'(full), 32'd1);
      // 3: round-robin eviction
      do_flush();
      check("t3.flush_full", 32'(full), 32'd0);
      lookup("t3.flushed", 8'h11, 1'b0, 32'hDEAD);
      for (int k = 1; k <= 4; k++) wr(8'(k), 32'h100 + 32'(k));
      check("t3.full", 32'(full), 32'd1);
      wr(8'd5, 32'h105);
      wr(8'd6, 32'h106);
      lookup("t3.k1", 8'd1, 1'b0, 32'hDEAD);
      lookup("t3.k2", 8'd2, 1'b0, 32'hDEAD);
      for (int k = 3; k <= 6; k++) lookup($sformatf("t3.k%0d", k), 8'(k), 1'b1, 32'h100 + 32'(k));
      check("t3.full_after", 32'(full), 32'd1);
      // 4: read-before-write, and write beats invalidate
      do_flush();
      wr_en = 1'b1; wr_key = 8'h33; wr_data = 32'h55;
      lookup("t4.same_cycle", 8'h33, 1'b0, 32'hDEAD);
      wr_en = 1'b0;
      lookup("t4.next_cycle", 8'h33, 1'b1, 32'h55);
      wr_en = 1'b1; wr_key = 8'h33; wr_data = 32'h77;
      inv_en = 1'b1; inv_key = 8'h33;
      tick();
      wr_en = 1'b0; inv_en = 1'b0;
      lookup("t4.wr_over_inv", 8'h33, 1'b1, 32'h77);
      inv_en = 1'b1; inv_key = 8'h33;
      tick();
      inv_en = 1'b0;
      lookup("t4.inv", 8'h33, 1'b0, 32'hDEAD);
      // 5: backpressure then full throughput
      for (int k = 1; k <= 4; k++) wr(8'hA0 + 8'(k), 32'hD0 + 32'(k));
      tick();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_key    = 8'hA1;
      tick();
      req_key = 8'hA2;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("t5.stall%0d.ready", c), 32'(req_ready), 32'd0);
         check($sformatf("t5.stall%0d.valid", c), 32'(resp_valid), 32'd1);
         check($sformatf("t5.stall%0d.data", c), resp_data, 32'hD1);
      end
      resp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         req_key = 8'hA0 + 8'(((c + 1) % 4) + 1);
         tick();
         check($sformatf("t5.flow%0d.valid", c), 32'(resp_valid), 32'd1);
         check($sformatf("t5.flow%0d.data", c), resp_data, 32'hD0 + 32'(((c + 1) % 4) + 1));
      end
      req_valid = 1'b0;
      tick();
      check("t5.drain", 32'(resp_valid), 32'd0);
      // 6: reset with a pending response and a full table
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_key    = 8'hA1;
      tick();
      req_valid = 1'b0;
      check("t6.pending", 32'(resp_valid), 32'd1);
      check("t6.full_before", 32'(full), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6.resp_valid", 32'(resp_valid), 32'd0);
      check("t6.nd_resp_valid", 32'(nd_resp_valid), 32'd0);
      check("t6.full", 32'(full), 32'd0);
      check("t6.nd_full", 32'(nd_full), 32'd0);
      resp_ready = 1'b1;
      lookup("t6.kA1", 8'hA1, 1'b0, 32'hDEAD);
      lookup("t6.kA4", 8'hA4, 1'b0, 32'hDEAD);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
